// File: rtl/nn_decision_stage.sv
// Argmax over three output-neuron scores plus consecutive-frame hysteresis for the drowsiness alarm.
// Optional macro CONF_MARGIN_EN: frames whose winner leads the runner-up by less than MARGIN report class 3.
module nn_decision_stage #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned ALARM_FRAMES = 8,
    parameter int unsigned CLEAR_FRAMES = 4,
    parameter int unsigned MARGIN       = 16
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] score0,
    input  logic [DATA_W-1:0] score1,
    input  logic [DATA_W-1:0] score2,
    output logic [1:0]        class_idx,
    output logic              class_valid,
    output logic [3:0]        drowsy_cnt,
    output logic              alarm
);

    localparam logic [3:0] AlarmMax = 4'(ALARM_FRAMES);
    localparam logic [3:0] ClearMax = 4'(CLEAR_FRAMES);

    typedef enum logic [1:0] {StIdle, StCmp1, StCmp2, StUpdate} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        class_idx_q, class_idx_d;
    logic              class_valid_q, class_valid_d;
    logic [3:0]        drowsy_q, drowsy_d;
    logic [3:0]        clear_q, clear_d;
    logic              alarm_q, alarm_d;

`ifdef CONF_MARGIN_EN
    localparam logic [DATA_W:0] MarginW = (DATA_W+1)'(MARGIN);
    logic [DATA_W-1:0] second_q, second_d;
    logic [DATA_W:0]   lead;

    // best >= second always holds, so the extra bit only guards the subtract
    assign lead = {1'b0, best_q} - {1'b0, second_q};
`else
    logic unused_margin;
    assign unused_margin = ^MARGIN;
`endif

    always_comb begin
        state_d       = state_q;
        s0_d          = s0_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        best_d        = best_q;
        idx_d         = idx_q;
        class_idx_d   = class_idx_q;
        class_valid_d = 1'b0;
        drowsy_d      = drowsy_q;
        clear_d       = clear_q;
        alarm_d       = alarm_q;
`ifdef CONF_MARGIN_EN
        second_d      = second_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s0_d    = score0;
                    s1_d    = score1;
                    s2_d    = score2;
                    state_d = StCmp1;
                end
            end
            StCmp1: begin
                // strict > so the lower index wins ties
                if (s1_q > s0_q) begin
                    best_d = s1_q;
                    idx_d  = 2'd1;
`ifdef CONF_MARGIN_EN
                    second_d = s0_q;
`endif
                end else begin
                    best_d = s0_q;
                    idx_d  = 2'd0;
`ifdef CONF_MARGIN_EN
                    second_d = s1_q;
`endif
                end
                state_d = StCmp2;
            end
            StCmp2: begin
                if (s2_q > best_q) begin
                    best_d = s2_q;
                    idx_d  = 2'd2;
`ifdef CONF_MARGIN_EN
                    second_d = best_q;
`endif
                end
`ifdef CONF_MARGIN_EN
                else if (s2_q > second_q) begin
                    second_d = s2_q;
                end
`endif
                state_d = StUpdate;
            end
            StUpdate: begin
                class_valid_d = 1'b1;
                state_d       = StIdle;
`ifdef CONF_MARGIN_EN
                if (lead < MarginW) class_idx_d = 2'd3;
                else
`endif
                begin
                    class_idx_d = idx_q;
                    if (idx_q == 2'd0) begin
                        drowsy_d = '0;
                        clear_d  = (clear_q == ClearMax) ? clear_q : clear_q + 4'd1;
                        if (clear_d == ClearMax) alarm_d = 1'b0;
                    end else begin
                        clear_d  = '0;
                        drowsy_d = (drowsy_q == AlarmMax) ? drowsy_q : drowsy_q + 4'd1;
                        if (drowsy_d == AlarmMax) alarm_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_q       <= StIdle;
            s0_q          <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            best_q        <= '0;
            idx_q         <= '0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
            drowsy_q      <= '0;
            clear_q       <= '0;
            alarm_q       <= 1'b0;
`ifdef CONF_MARGIN_EN
            second_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            best_q        <= best_d;
            idx_q         <= idx_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
            drowsy_q      <= drowsy_d;
            clear_q       <= clear_d;
            alarm_q       <= alarm_d;
`ifdef CONF_MARGIN_EN
            second_q      <= second_d;
`endif
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;
    assign drowsy_cnt  = drowsy_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_nn_decision_stage.sv
// Scoreboard bench for nn_decision_stage: stimulus pushes model expectations, a negedge monitor pops them.
module tb_nn_decision_stage;

    localparam int DW = 10;
    localparam int AF = 8;
    localparam int CF = 4;
    localparam int MG = 16;

    logic          Clock = 1'b0;
    logic          Rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] score0 = '0;
    logic [DW-1:0] score1 = '0;
    logic [DW-1:0] score2 = '0;
    logic [1:0]    class_idx;
    logic          class_valid;
    logic [3:0]    drowsy_cnt;
    logic          alarm;

    nn_decision_stage dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .score0     (score0),
        .score1     (score1),
        .score2     (score2),
        .class_idx  (class_idx),
        .class_valid(class_valid),
        .drowsy_cnt (drowsy_cnt),
        .alarm      (alarm)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [1:0] cls;
        logic [3:0] cnt;
        logic       alm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_drowsy = 0;
    int   m_clear = 0;
    bit   m_alarm = 1'b0;

    function automatic void check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endfunction

    // Reference: argmax with lowest-index tie break, then saturating hysteresis counters.
    task automatic model(input int a, input int b, input int c);
        int   s[3];
        int   w;
        int   sec;
        exp_t e;
        s   = '{a, b, c};
        w   = 0;
        sec = -1;
        for (int i = 1; i < 3; i++) if (s[i] > s[w]) w = i;
        for (int i = 0; i < 3; i++) if (i != w && s[i] > sec) sec = s[i];
`ifdef CONF_MARGIN_EN
        if (s[w] - sec < MG) begin
            e.cls = 2'd3;
            e.cnt = 4'(m_drowsy);
            e.alm = m_alarm;
            exp_q.push_back(e);
            return;
        end
`endif
        if (w == 0) begin
            m_drowsy = 0;
            m_clear  = (m_clear + 1 > CF) ? CF : m_clear + 1;
            if (m_clear == CF) m_alarm = 1'b0;
        end else begin
            m_clear  = 0;
            m_drowsy = (m_drowsy + 1 > AF) ? AF : m_drowsy + 1;
            if (m_drowsy == AF) m_alarm = 1'b1;
        end
        e.cls = 2'(w);
        e.cnt = 4'(m_drowsy);
        e.alm = m_alarm;
        exp_q.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic send(input int a, input int b, input int c, input bit hold);
        check("ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        score0   = DW'(a);
        score1   = DW'(b);
        score2   = DW'(c);
        model(a, b, c);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            in_valid = hold;
            score0   = DW'($urandom);
            score1   = DW'($urandom);
            score2   = DW'($urandom);
            check("ready_busy", int'(in_ready), 0);
        end
        @(negedge Clock);
        in_valid = 1'b0;
        check("ready_back", int'(in_ready), 1);
    endtask

    function automatic int rnd_score();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0: return 0;
            1: return 1023;
            2: return 500;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Rst && class_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_class_valid: got class %0d, want no pulse", class_idx);
            end else begin
                e = exp_q.pop_front();
                check("class_idx", int'(class_idx), int'(e.cls));
                check("drowsy_cnt", int'(drowsy_cnt), int'(e.cnt));
                check("alarm", int'(alarm), int'(e.alm));
            end
        end
    end

    initial begin
        int a;
        int b;
        int c;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Rst = 1'b1;
        check("rst_ready", int'(in_ready), 1);
        check("rst_class_idx", int'(class_idx), 0);
        check("rst_class_valid", int'(class_valid), 0);
        check("rst_drowsy", int'(drowsy_cnt), 0);
        check("rst_alarm", int'(alarm), 0);

        send(100, 300, 200, 1'b1);
        send(50, 50, 50, 1'b0);
        send(10, 400, 400, 1'b1);
        send(0, 0, 1023, 1'b0);
        send(900, 0, 0, 1'b0);

        for (int i = 0; i < 10; i++) send(0, 0, 900, 1'b0);
        check("sat_drowsy", int'(drowsy_cnt), AF);
        check("sat_alarm", int'(alarm), 1);
        for (int i = 0; i < 3; i++) send(900, 0, 0, 1'b0);
        check("hold_alarm", int'(alarm), 1);
        send(900, 0, 0, 1'b0);
        check("clear_alarm", int'(alarm), 0);

        for (int i = 0; i < 5; i++) send(0, 0, 900, 1'b0);
        check("pre_rst_drowsy", int'(drowsy_cnt), 5);
        // Frame aborted by reset while in its second compare cycle
        in_valid = 1'b1;
        score0   = DW'(0);
        score1   = DW'(0);
        score2   = DW'(900);
        @(negedge Clock);
        in_valid = 1'b0;
        check("mid_ready_busy", int'(in_ready), 0);
        @(negedge Clock);
        Rst = 1'b0;
        @(negedge Clock);
        Rst = 1'b1;
        m_drowsy = 0;
        m_clear  = 0;
        m_alarm  = 1'b0;
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_class_idx", int'(class_idx), 0);
        check("mid_rst_class_valid", int'(class_valid), 0);
        check("mid_rst_drowsy", int'(drowsy_cnt), 0);
        check("mid_rst_alarm", int'(alarm), 0);
        send(0, 700, 3, 1'b0);

`ifdef CONF_MARGIN_EN
        send(200, 210, 0, 1'b0);
        send(200, 216, 0, 1'b0);
`endif

        for (int i = 0; i < 200; i++) begin
            a = rnd_score();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_score();
            c = ($urandom_range(0, 3) == 0) ? b : rnd_score();
            if ($urandom_range(0, 2) == 0) a = int'($urandom_range(0, 1023));
            send(a, b, c, 1'($urandom));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
